// File: rtl/repairmb_lane_decider_if.sv
`default_nettype none
// ============================================================================
// Module      : repairmb_lane_decider_if
// Description : Degrade-message channel between the REPAIRMB lane decider
//               (master) and the sideband message encoder / partner response
//               path (slave). Carries the valid/ready degrade message and the
//               partner's echoed lane code.
// Revision    : 1.0 - initial release
// ============================================================================
interface repairmb_lane_decider_if;
  logic       o_degrade_valid;
  logic [1:0] o_functional_lanes;
  logic       i_degrade_ready;
  logic       i_resp_valid;
  logic [1:0] i_resp_lanes;

  modport master (
    output o_degrade_valid,
    output o_functional_lanes,
    input  i_degrade_ready,
    input  i_resp_valid,
    input  i_resp_lanes
  );

  modport slave (
    input  o_degrade_valid,
    input  o_functional_lanes,
    output i_degrade_ready,
    output i_resp_valid,
    output i_resp_lanes
  );
endinterface
`default_nettype wire

// File: rtl/repairmb_lane_decider.sv
`default_nettype none
// ============================================================================
// Module      : repairmb_lane_decider
// Description : MBINIT REPAIRMB initiator sequencer. Encodes per-lane test
//               results into a 2-bit functional-lane code, sends it over the
//               degrade channel, checks the partner echo and requests one
//               retest for a half-width result. Ends in DONE or ERROR.
//               Optional wait-state timeout: define REPAIRMB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module repairmb_lane_decider #(
  parameter int NUM_LANES      = 16,
  parameter int TIMEOUT_CYCLES = 800000
) (
  input  wire logic                 CLK,
  input  wire logic                 rst,
  input  wire logic                 i_en,
  input  wire logic                 i_result_valid,
  input  wire logic [NUM_LANES-1:0] i_lane_pass,
  repairmb_lane_decider_if.master   deg,
  output logic                      o_req_retest,
  output logic                      o_done,
  output logic                      o_train_error,
  output logic [1:0]                o_lanes_final
);

  localparam int c_half = NUM_LANES / 2;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_WAIT_RESULT = 3'd1,
    ST_ENCODE      = 3'd2,
    ST_SEND        = 3'd3,
    ST_WAIT_RESP   = 3'd4,
    ST_DONE        = 3'd5,
    ST_ERROR       = 3'd6
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [NUM_LANES-1:0] r_lanes;
  logic [1:0]           r_cur_code;
  logic [1:0]           r_first_code;
  logic                 r_second_round;
  logic [1:0]           w_code;
  logic [1:0]           w_cur_code_nxt;
  logic [1:0]           w_first_code_nxt;
  logic                 w_second_round_nxt;
  logic                 w_retest;
  logic                 w_timeout;

  // bit0 = lower half all pass, bit1 = upper half all pass
  assign w_code = {&r_lanes[NUM_LANES-1:c_half], &r_lanes[c_half-1:0]};

`ifdef REPAIRMB_TIMEOUT_EN
  localparam int                 c_tmo_w    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT_CYCLES - 1);

  logic [c_tmo_w-1:0] r_tmo_cnt;
  logic               w_in_wait;

  assign w_in_wait = (r_state == ST_WAIT_RESULT) || (r_state == ST_SEND) ||
                     (r_state == ST_WAIT_RESP);
  assign w_timeout = w_in_wait && (r_tmo_cnt == c_tmo_last);

  // Wait-state cycle counter; any state change restarts it so every wait
  // state is entered with a count of zero
  always_ff @(posedge CLK) begin
    if (rst)                   r_tmo_cnt <= '0;
    else if (w_next != r_state) r_tmo_cnt <= '0;
    else if (w_in_wait)        r_tmo_cnt <= r_tmo_cnt + c_tmo_w'(1);
  end
`else
  assign w_timeout = 1'b0;
  // Timeout disabled: the parameter stays on the port list so both builds
  // share one instantiation footprint
  if (TIMEOUT_CYCLES > 0) begin : g_tmo_disabled
  end
`endif

  // Next-state and next-value logic; i_en low overrides everything
  always_comb begin
    w_next             = r_state;
    w_cur_code_nxt     = r_cur_code;
    w_first_code_nxt   = r_first_code;
    w_second_round_nxt = r_second_round;
    w_retest           = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_en) begin
          w_next             = ST_WAIT_RESULT;
          w_second_round_nxt = 1'b0;
        end
      end
      ST_WAIT_RESULT: begin
        if (i_result_valid) w_next = ST_ENCODE;
        else if (w_timeout) w_next = ST_ERROR;
      end
      ST_ENCODE: begin
        w_cur_code_nxt = w_code;
        // A retest that disagrees with the first result is a hard failure
        if (r_second_round && (w_code != r_first_code)) w_next = ST_ERROR;
        else                                            w_next = ST_SEND;
      end
      ST_SEND: begin
        if (deg.i_degrade_ready) w_next = ST_WAIT_RESP;
        else if (w_timeout)      w_next = ST_ERROR;
      end
      ST_WAIT_RESP: begin
        if (deg.i_resp_valid) begin
          if ((deg.i_resp_lanes != r_cur_code) || (r_cur_code == 2'b00)) begin
            w_next = ST_ERROR;
          end else if ((r_cur_code == 2'b11) || r_second_round) begin
            w_next = ST_DONE;
          end else begin
            w_first_code_nxt   = r_cur_code;
            w_second_round_nxt = 1'b1;
            w_retest           = 1'b1;
            w_next             = ST_WAIT_RESULT;
          end
        end else if (w_timeout) begin
          w_next = ST_ERROR;
        end
      end
      ST_DONE:  w_next = ST_DONE;
      ST_ERROR: w_next = ST_ERROR;
      default:  w_next = ST_IDLE;
    endcase
    if (!i_en) begin
      w_next   = ST_IDLE;
      w_retest = 1'b0;
    end
  end

  // State and datapath registers
  always_ff @(posedge CLK) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_lanes        <= '0;
      r_cur_code     <= 2'b00;
      r_first_code   <= 2'b00;
      r_second_round <= 1'b0;
    end else begin
      r_state        <= w_next;
      r_cur_code     <= w_cur_code_nxt;
      r_first_code   <= w_first_code_nxt;
      r_second_round <= w_second_round_nxt;
      if ((r_state == ST_WAIT_RESULT) && i_result_valid) r_lanes <= i_lane_pass;
    end
  end

  // Registered outputs, decoded from the state being entered
  always_ff @(posedge CLK) begin
    if (rst) begin
      deg.o_degrade_valid    <= 1'b0;
      deg.o_functional_lanes <= 2'b00;
      o_req_retest           <= 1'b0;
      o_done                 <= 1'b0;
      o_train_error          <= 1'b0;
      o_lanes_final          <= 2'b00;
    end else begin
      deg.o_degrade_valid    <= (w_next == ST_SEND);
      deg.o_functional_lanes <= (w_next == ST_SEND) ? w_cur_code_nxt : 2'b00;
      o_req_retest           <= w_retest;
      o_done                 <= (w_next == ST_DONE);
      o_train_error          <= (w_next == ST_ERROR);
      o_lanes_final          <= (w_next == ST_DONE) ? w_cur_code_nxt : 2'b00;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_repairmb_lane_decider.sv
`default_nettype none
// ============================================================================
// Module      : tb_repairmb_lane_decider
// Description : Directed self-checking bench for repairmb_lane_decider with
//               NUM_LANES=16 and TIMEOUT_CYCLES=20.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_repairmb_lane_decider;

  logic        CLK = 1'b0;
  logic        rst;
  logic        i_en;
  logic        i_result_valid;
  logic [15:0] i_lane_pass;
  logic        o_req_retest;
  logic        o_done;
  logic        o_train_error;
  logic [1:0]  o_lanes_final;

  int n_total = 0;
  int n_pass  = 0;

  repairmb_lane_decider_if bus ();

  repairmb_lane_decider #(
    .NUM_LANES      (16),
    .TIMEOUT_CYCLES (20)
  ) dut (
    .CLK            (CLK),
    .rst            (rst),
    .i_en           (i_en),
    .i_result_valid (i_result_valid),
    .i_lane_pass    (i_lane_pass),
    .deg            (bus),
    .o_req_retest   (o_req_retest),
    .o_done         (o_done),
    .o_train_error  (o_train_error),
    .o_lanes_final  (o_lanes_final)
  );

  // 100 MHz clock
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Return to IDLE then enter WAIT_RESULT
  task automatic restart();
    i_en = 1'b0;
    tick();
    i_en = 1'b1;
    tick();
  endtask

  // Result pulse; leaves the DUT in its first SEND cycle
  task automatic give_result(input logic [15:0] pass);
    i_result_valid = 1'b1;
    i_lane_pass    = pass;
    tick();
    i_result_valid = 1'b0;
    tick();
  endtask

  task automatic handshake();
    bus.i_degrade_ready = 1'b1;
    tick();
    bus.i_degrade_ready = 1'b0;
  endtask

  task automatic respond(input logic [1:0] code);
    bus.i_resp_valid = 1'b1;
    bus.i_resp_lanes = code;
    tick();
    bus.i_resp_valid = 1'b0;
    bus.i_resp_lanes = 2'b00;
  endtask

  initial begin
    rst                 = 1'b1;
    i_en                = 1'b0;
    i_result_valid      = 1'b0;
    i_lane_pass         = '0;
    bus.i_degrade_ready = 1'b0;
    bus.i_resp_valid    = 1'b0;
    bus.i_resp_lanes    = 2'b00;
    i_en                = 1'b1;
    tick();
    tick();

    // Reset state, with i_en already high to show rst priority
    check("rst_valid", 16'(bus.o_degrade_valid), 16'd0);
    check("rst_code",  16'(bus.o_functional_lanes), 16'd0);
    check("rst_done",  16'(o_done), 16'd0);
    check("rst_err",   16'(o_train_error), 16'd0);
    check("rst_retest", 16'(o_req_retest), 16'd0);
    check("rst_final", 16'(o_lanes_final), 16'd0);
    rst = 1'b0;
    tick();  // WAIT_RESULT

    // Test 1: all lanes pass, immediate ready, resp 11
    i_result_valid = 1'b1;
    i_lane_pass    = 16'hFFFF;
    tick();  // ENCODE
    i_result_valid = 1'b0;
    check("t1_encode_valid", 16'(bus.o_degrade_valid), 16'd0);
    tick();  // SEND
    check("t1_send_valid", 16'(bus.o_degrade_valid), 16'd1);
    check("t1_send_code",  16'(bus.o_functional_lanes), 16'd3);
    handshake();
    check("t1_valid_drop", 16'(bus.o_degrade_valid), 16'd0);
    respond(2'b11);
    check("t1_done",   16'(o_done), 16'd1);
    check("t1_final",  16'(o_lanes_final), 16'd3);
    check("t1_retest", 16'(o_req_retest), 16'd0);
    tick();
    check("t1_done_held", 16'(o_done), 16'd1);

    // Test 2: lane 12 fails -> 01, retest, second result 01 -> DONE
    restart();
    give_result(16'hEFFF);
    check("t2_code1", 16'(bus.o_functional_lanes), 16'd1);
    handshake();
    respond(2'b01);
    check("t2_retest_pulse", 16'(o_req_retest), 16'd1);
    check("t2_not_done",     16'(o_done), 16'd0);
    tick();
    check("t2_retest_low", 16'(o_req_retest), 16'd0);
    give_result(16'h00FF);
    check("t2_code2",  16'(bus.o_functional_lanes), 16'd1);
    handshake();
    respond(2'b01);
    check("t2_done",   16'(o_done), 16'd1);
    check("t2_final",  16'(o_lanes_final), 16'd1);
    check("t2_no_retest", 16'(o_req_retest), 16'd0);

    // Test 3: lane 3 fails -> 10, retest gives 01 -> ERROR from ENCODE
    restart();
    give_result(16'hFFF7);
    check("t3_code1", 16'(bus.o_functional_lanes), 16'd2);
    handshake();
    respond(2'b10);
    check("t3_retest", 16'(o_req_retest), 16'd1);
    i_result_valid = 1'b1;
    i_lane_pass    = 16'hFBFF;
    tick();  // ENCODE
    i_result_valid = 1'b0;
    tick();  // ERROR
    check("t3_err",      16'(o_train_error), 16'd1);
    check("t3_no_valid", 16'(bus.o_degrade_valid), 16'd0);
    tick();
    check("t3_no_valid2", 16'(bus.o_degrade_valid), 16'd0);

    // Test 4: lanes 0 and 15 fail -> code 00 is still sent, then ERROR
    restart();
    give_result(16'h7FFE);
    check("t4_valid", 16'(bus.o_degrade_valid), 16'd1);
    check("t4_code",  16'(bus.o_functional_lanes), 16'd0);
    handshake();
    respond(2'b00);
    check("t4_err",  16'(o_train_error), 16'd1);
    check("t4_done", 16'(o_done), 16'd0);

    // Test 5: ready held low 5 cycles, then drop i_en in WAIT_RESP
    restart();
    give_result(16'hFFFF);
    for (int i = 0; i < 5; i++) begin
      check("t5_hold_valid", 16'(bus.o_degrade_valid), 16'd1);
      check("t5_hold_code",  16'(bus.o_functional_lanes), 16'd3);
      tick();
    end
    check("t5_hold_valid_end", 16'(bus.o_degrade_valid), 16'd1);
    handshake();
    check("t5_wait_resp", 16'(bus.o_degrade_valid), 16'd0);
    i_en = 1'b0;
    tick();
    check("t5_abort_valid",  16'(bus.o_degrade_valid), 16'd0);
    check("t5_abort_code",   16'(bus.o_functional_lanes), 16'd0);
    check("t5_abort_done",   16'(o_done), 16'd0);
    check("t5_abort_err",    16'(o_train_error), 16'd0);
    check("t5_abort_retest", 16'(o_req_retest), 16'd0);
    // A response while in IDLE must not move anything
    respond(2'b11);
    check("t5_idle_done", 16'(o_done), 16'd0);
    check("t5_idle_err",  16'(o_train_error), 16'd0);

    // Test 6: stray pulses ignored, then mismatching echo -> ERROR
    restart();
    give_result(16'h00FF);
    respond(2'b01);  // in SEND: ignored
    check("t6_send_ignores_resp", 16'(bus.o_degrade_valid), 16'd1);
    check("t6_send_code", 16'(bus.o_functional_lanes), 16'd1);
    handshake();
    i_result_valid = 1'b1;  // in WAIT_RESP: ignored
    i_lane_pass    = 16'hFFFF;
    tick();
    i_result_valid = 1'b0;
    check("t6_resp_ignores_result", 16'(bus.o_degrade_valid), 16'd0);
    respond(2'b10);
    check("t6_mismatch_err", 16'(o_train_error), 16'd1);
    check("t6_mismatch_retest", 16'(o_req_retest), 16'd0);

    // Test 7: reset mid-message drops valid on the next edge
    restart();
    give_result(16'hFFFF);
    check("t7_valid", 16'(bus.o_degrade_valid), 16'd1);
    rst = 1'b1;
    tick();
    check("t7_rst_drop", 16'(bus.o_degrade_valid), 16'd0);
    rst = 1'b0;

    // Test 8: no response in WAIT_RESP
    restart();
    give_result(16'hFFFF);
    handshake();
`ifdef REPAIRMB_TIMEOUT_EN
    repeat (19) tick();
    check("t8_tmo_early", 16'(o_train_error), 16'd0);
    tick();
    check("t8_tmo_err", 16'(o_train_error), 16'd1);
`else
    repeat (1000) tick();
    check("t8_no_tmo_err",  16'(o_train_error), 16'd0);
    check("t8_no_tmo_done", 16'(o_done), 16'd0);
    respond(2'b11);
    check("t8_late_done", 16'(o_done), 16'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
